// File: rtl/pipelined_carry_adder_pkg.sv
// Shared configuration for the pipelined carry adder.
//   - Default operand width and pipeline depth.
//   - Configuration legality check used at elaboration time by the top level.
package pipelined_carry_adder_pkg;

    localparam int unsigned PCA_DEFAULT_NUMBITS   = 32;
    localparam int unsigned PCA_DEFAULT_NUMSTAGES = 4;

    // Depth must be 1..width and divide the width into equal chunks.
    function automatic bit pca_cfg_ok(input int unsigned nbits, input int unsigned nstages);
        return (nstages >= 1) && (nstages <= nbits) && ((nbits % nstages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_stage.sv
// One pipeline stage of the pipelined carry adder.
//   Adds chunk STAGE of the (already conditioned) operands with the incoming
//   carry using a CHUNK-bit ripple slice, merges it into the partial sum and
//   registers the whole transaction when i_load is high.
// Ports:
//   clk, reset              clock, async active-low reset
//   i_load                  stage may capture this cycle
//   i_valid                 upstream transaction present
//   i_a, i_b                full operands (upper chunks still unconsumed)
//   i_sum                   partial sum, chunks below STAGE filled in
//   i_carry                 carry into this chunk
//   o_valid/o_a/o_b/o_sum/o_carry  registered stage contents
module pipelined_carry_adder_stage
    import pipelined_carry_adder_pkg::*;
#(
    parameter int unsigned NUMBITS = PCA_DEFAULT_NUMBITS,
    parameter int unsigned CHUNK   = PCA_DEFAULT_NUMBITS / PCA_DEFAULT_NUMSTAGES,
    parameter int unsigned STAGE   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_valid,
    input  logic [NUMBITS-1:0] i_a,
    input  logic [NUMBITS-1:0] i_b,
    input  logic [NUMBITS-1:0] i_sum,
    input  logic               i_carry,
    output logic               o_valid,
    output logic [NUMBITS-1:0] o_a,
    output logic [NUMBITS-1:0] o_b,
    output logic [NUMBITS-1:0] o_sum,
    output logic               o_carry
);

    localparam int unsigned LSB = STAGE * CHUNK;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum_chunk;
    logic               w_ripple;
    logic [NUMBITS-1:0] w_next_sum;

    logic               r_valid;
    logic [NUMBITS-1:0] r_a;
    logic [NUMBITS-1:0] r_b;
    logic [NUMBITS-1:0] r_sum;
    logic               r_carry;

    assign w_a_chunk = i_a[LSB +: CHUNK];
    assign w_b_chunk = i_b[LSB +: CHUNK];

    // Ripple-carry slice over this stage's chunk.
    always_comb begin
        w_sum_chunk = '0;
        w_ripple    = i_carry;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            w_sum_chunk[i] = w_a_chunk[i] ^ w_b_chunk[i] ^ w_ripple;
            w_ripple       = (w_a_chunk[i] & w_b_chunk[i]) | (w_ripple & (w_a_chunk[i] ^ w_b_chunk[i]));
        end
    end

    // Merge this chunk into the partial sum carried from upstream.
    always_comb begin
        w_next_sum             = i_sum;
        w_next_sum[LSB +: CHUNK] = w_sum_chunk;
    end

    // Valid follows every load so bubbles collapse; data only moves with a real transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_sum   <= w_next_sum;
                r_carry <= w_ripple;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined carry adder: NUMBITS-wide add split into NUMSTAGES ripple chunks,
// carry registered between stages, one add per clock, valid/ready on both sides.
// Optional macro PCA_SUB_EN adds a 'sub' input: b is inverted and the carry in
// is forced to 1 (carryout=1 then means no borrow).
// Ports:
//   clk, reset           clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_ready is combinational from out_ready)
//   a, b, carryin        operands and carry into bit 0
//   sub                  subtract select (PCA_SUB_EN only)
//   out_valid/out_ready  result handshake
//   result, carryout     sum mod 2^NUMBITS and carry out of the MSB
//   overflow             signed two's-complement overflow
module pipelined_carry_adder
    import pipelined_carry_adder_pkg::*;
#(
    parameter int unsigned NUMBITS   = PCA_DEFAULT_NUMBITS,
    parameter int unsigned NUMSTAGES = PCA_DEFAULT_NUMSTAGES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               carryin,
`ifdef PCA_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow
);

    localparam int unsigned CHUNK = NUMBITS / NUMSTAGES;
    localparam int unsigned MSB   = NUMBITS - 1;

    if (!pca_cfg_ok(NUMBITS, NUMSTAGES)) begin : g_cfg_error
        $error("pipelined_carry_adder: NUMBITS must be a multiple of NUMSTAGES, 1 <= NUMSTAGES <= NUMBITS");
    end

    // Index 0 is the pipeline input; index k+1 is the output of stage k.
    logic [NUMSTAGES:0] w_v;
    logic [NUMSTAGES:0] w_c;
    logic [NUMSTAGES:0] w_ld;
    logic [NUMBITS-1:0] w_a   [NUMSTAGES+1];
    logic [NUMBITS-1:0] w_b   [NUMSTAGES+1];
    logic [NUMBITS-1:0] w_sum [NUMSTAGES+1];

    logic [NUMBITS-1:0] w_b_eff;
    logic               w_cin_eff;
    logic [NUMBITS-1:0] w_a_last;
    logic [NUMBITS-1:0] w_b_last;
    logic               w_unused_last_ops;

    // Operand conditioning: subtraction is a + ~b + 1.
`ifdef PCA_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | carryin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = carryin;
`endif

    assign w_v[0]   = in_valid;
    assign w_a[0]   = a;
    assign w_b[0]   = w_b_eff;
    assign w_sum[0] = '0;
    assign w_c[0]   = w_cin_eff;

    // Advance chain from the consumer back to the input; a stage loads when empty or draining.
    always_comb begin
        w_ld            = '0;
        w_ld[NUMSTAGES] = out_ready;
        for (int k = int'(NUMSTAGES) - 1; k >= 0; k--) begin
            w_ld[k] = !w_v[k+1] || w_ld[k+1];
        end
    end

    assign in_ready = w_ld[0];

    for (genvar k = 0; k < NUMSTAGES; k++) begin : g_stage
        pipelined_carry_adder_stage #(
            .NUMBITS (NUMBITS),
            .CHUNK   (CHUNK),
            .STAGE   (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_ld[k]),
            .i_valid (w_v[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_sum   (w_sum[k]),
            .i_carry (w_c[k]),
            .o_valid (w_v[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_sum   (w_sum[k+1]),
            .o_carry (w_c[k+1])
        );
    end

    assign w_a_last  = w_a[NUMSTAGES];
    assign w_b_last  = w_b[NUMSTAGES];

    assign out_valid = w_v[NUMSTAGES];
    assign result    = w_sum[NUMSTAGES];
    assign carryout  = w_c[NUMSTAGES];

    // Signed overflow from final-stage registers; all-zero after reset gives 0.
    assign overflow  = (w_a_last[MSB] == w_b_last[MSB]) && (result[MSB] != w_a_last[MSB]);

    // Only the operand MSBs are needed at the end of the pipe.
    assign w_unused_last_ops = ^{w_a_last, w_b_last};

endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;

    localparam int unsigned NB = 32;
    localparam int unsigned NS = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [NB-1:0] a         = '0;
    logic [NB-1:0] b         = '0;
    logic          carryin   = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NB-1:0] result;
    logic          carryout;
    logic          overflow;
`ifdef PCA_SUB_EN
    logic          sub       = 1'b0;
    wire           sub_val   = sub;
`else
    wire           sub_val   = 1'b0;
`endif

    always #5 clk = ~clk;

    pipelined_carry_adder #(
        .NUMBITS   (NB),
        .NUMSTAGES (NS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carryin   (carryin),
`ifdef PCA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_push = 0;

    logic [NB+1:0] exp_q [$];
    int            pop_cyc [$];
    logic [NB+1:0] exp_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {overflow, carryout, result}
    function automatic logic [NB+1:0] model(input logic [NB-1:0] ma, input logic [NB-1:0] mb,
                                            input logic mc, input logic ms);
        logic [NB-1:0] be;
        logic          ci;
        logic [NB:0]   s;
        logic          ov;
        be = ms ? ~mb : mb;
        ci = ms ? 1'b1 : mc;
        s  = {1'b0, ma} + {1'b0, be} + (NB+1)'(ci);
        ov = (ma[NB-1] == be[NB-1]) && (s[NB-1] != ma[NB-1]);
        return {ov, s[NB], s[NB-1:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: sample handshakes mid-cycle, push on accept, pop on delivery.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 64'(1), 64'(0));
                end else begin
                    exp_e = exp_q.pop_front();
                    check_val("result",   64'(result),   64'(exp_e[NB-1:0]));
                    check_val("carryout", 64'(carryout), 64'(exp_e[NB]));
                    check_val("overflow", 64'(overflow), 64'(exp_e[NB+1]));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, carryin, sub_val));
                n_push++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] ta, input logic [NB-1:0] tb_v, input logic tc, input logic ts);
        logic acc;
        bit   done;
        done     = 1'b0;
        a        = ta;
        b        = tb_v;
        carryin  = tc;
`ifdef PCA_SUB_EN
        sub      = ts;
`else
        if (ts) $display("note: sub ignored in this build");
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) check_val("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) check_val("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            base_push;
        int            base_pop;
        logic [NB-1:0] res0;
        bit            sdone;

        // Reset state
        repeat (3) tick();
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_result",    64'(result),    64'(0));
        reset = 1'b1;
        tick();
        check_val("rst_in_ready",  64'(in_ready),  64'(1));
        check_val("rst_carryout",  64'(carryout),  64'(0));
        check_val("rst_overflow",  64'(overflow),  64'(0));

        // Basic add and latency
        out_ready = 1'b1;
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
        lat = -1;
        if (out_valid) lat = 0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            tick();
            if (out_valid) lat = n;
        end
        check_val("latency", 64'(lat), 64'(NS - 1));
        check_val("t1_result", 64'(result), 64'(32'h9999_9999));
        drain();

        // Carry across every boundary and signed overflow
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        // Back-to-back throughput
        base_pop = pop_cyc.size();
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        drain();
        check_val("b2b_count", 64'(pop_cyc.size() - base_pop), 64'(8));
        if (pop_cyc.size() - base_pop == 8)
            check_val("b2b_span", 64'(pop_cyc[base_pop+7] - pop_cyc[base_pop]), 64'(7));

        // Back-pressure: full pipeline holds exactly NS and freezes outputs
        out_ready = 1'b0;
        base_push = n_push;
        base_pop  = pop_cyc.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                repeat (4) tick();
                res0 = result;
                repeat (2) tick();
                check_val("full_accepted", 64'(n_push - base_push), 64'(NS));
                check_val("full_in_ready", 64'(in_ready), 64'(0));
                check_val("full_out_valid", 64'(out_valid), 64'(1));
                check_val("stall_stable", 64'(result), 64'(res0));
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("stall_delivered", 64'(pop_cyc.size() - base_pop), 64'(6));

        // Reset with transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'(0));
        check_val("midrst_result",    64'(result),    64'(0));
        check_val("midrst_carryout",  64'(carryout),  64'(0));
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_val("postrst_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        base_pop  = pop_cyc.size();
        repeat (8) tick();
        check_val("no_stale", 64'(pop_cyc.size() - base_pop), 64'(0));

`ifdef PCA_SUB_EN
        // Subtraction
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b0, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        drain();
`endif

        // Random traffic with random back-pressure
        sdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                sdone = 1'b1;
            end
            begin
                for (int g = 0; g < 3000 && !sdone; g++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("leftover", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
